// File: rtl/pov_pkg.sv
// pov_pkg: shared FSM encodings and EEPROM opcode
// for the POV frame streamer.
package pov_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_LOAD,
    S_CHECK,
    S_RUN,
    S_ERROR
  } pov_state_e;

  localparam logic [7:0] EEPROM_READ_CMD = 8'h03;

endpackage

// File: rtl/spi_byte_engine.sv
// spi_byte_engine: mode-0 single-byte SPI master, MSB first.
// Ports: clk, nreset, start/abort, tx_byte, miso in;
//   sclk, mosi, done (last clk of byte), rx_byte out.
// A start on the done clk chains the next byte with no gap.
module spi_byte_engine #(
  parameter int SCLK_DIV = 1
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] tx_byte,
  input  logic       miso,
  output logic       sclk,
  output logic       mosi,
  output logic       done,
  output logic [7:0] rx_byte
);

  localparam int DW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

  logic          active;
  logic [DW-1:0] div;
  logic [3:0]    half;
  logic [7:0]    tx_sh;
  logic          tick;

  assign tick = (div == DW'(SCLK_DIV - 1));
  assign done = active & tick & (half == 4'hf);
  assign mosi = active & tx_sh[7];

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      active  <= 1'b0;
      div     <= '0;
      half    <= '0;
      tx_sh   <= '0;
      rx_byte <= '0;
      sclk    <= 1'b0;
    end else if (abort) begin
      active <= 1'b0;
      div    <= '0;
      half   <= '0;
      sclk   <= 1'b0;
    end else if (!active || done) begin
      div    <= '0;
      half   <= '0;
      sclk   <= 1'b0;
      active <= start;
      if (start) tx_sh <= tx_byte;
    end else if (tick) begin
      div  <= '0;
      half <= half + 4'd1;
      sclk <= ~sclk;
      // rising edge samples, falling edge shifts
      if (!sclk) rx_byte <= {rx_byte[6:0], miso};
      else       tx_sh   <= {tx_sh[6:0], 1'b0};
    end else begin
      div <= div + DW'(1);
    end
  end

endmodule

// File: rtl/pov_frame_streamer.sv
// pov_frame_streamer: bursts a frame from SPI EEPROM into a
// buffer, then shifts one column per col_strobe to HC595s.
// In: clk, nreset, run, col_strobe, dir, eeprom_miso.
// Out: eeprom_cs_n/sclk/mosi, hc595_sclk/dat/latch,
//   loaded, busy, overrun, error.
// Option: FRAME_CHECKSUM_EN adds a trailing XOR byte check.
module pov_frame_streamer
  import pov_pkg::*;
#(
  parameter int COLUMNS       = 100,
  parameter int BYTES_PER_COL = 1,
  parameter int ADDR_BYTES    = 1,
  parameter logic [ADDR_BYTES*8-1:0] START_ADDR = '0,
  parameter int SCLK_DIV      = 1
) (
  input  logic clk,
  input  logic nreset,
  input  logic run,
  input  logic col_strobe,
  input  logic dir,
  input  logic eeprom_miso,
  output logic eeprom_cs_n,
  output logic eeprom_sclk,
  output logic eeprom_mosi,
  output logic hc595_sclk,
  output logic hc595_dat,
  output logic hc595_latch,
  output logic loaded,
  output logic busy,
  output logic overrun,
  output logic error
);

  localparam int N  = COLUMNS * BYTES_PER_COL;
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(N + 4);
  localparam int PW = $clog2(COLUMNS);

`ifdef FRAME_CHECKSUM_EN
  localparam pov_state_e LOAD_NEXT = S_CHECK;
`else
  localparam pov_state_e LOAD_NEXT = S_RUN;
`endif

  pov_state_e    state, state_d;
  logic [CW-1:0] cnt;
  logic          ee_go;
  logic [7:0]    frame_buf [N];
  logic [PW-1:0] ptr, ptr_nxt;
  logic          dir_q, busy_q, latch_q, overrun_q;
  logic [1:0]    bidx;
  logic [IW-1:0] hc_idx;
  logic          in_burst, buf_we;

  logic       ee_start, ee_abort, ee_done;
  logic [7:0] ee_tx, ee_rx;
  logic       hc_start, hc_abort, hc_done;
  logic       col_go, hc_next;
  logic [7:0] hc_tx, unused_hc_rx;

`ifdef FRAME_CHECKSUM_EN
  logic [7:0] csum;
`endif

  spi_byte_engine #(.SCLK_DIV(SCLK_DIV)) u_ee (
    .clk     (clk),
    .nreset  (nreset),
    .start   (ee_start),
    .abort   (ee_abort),
    .tx_byte (ee_tx),
    .miso    (eeprom_miso),
    .sclk    (eeprom_sclk),
    .mosi    (eeprom_mosi),
    .done    (ee_done),
    .rx_byte (ee_rx)
  );

  spi_byte_engine #(.SCLK_DIV(SCLK_DIV)) u_hc (
    .clk     (clk),
    .nreset  (nreset),
    .start   (hc_start),
    .abort   (hc_abort),
    .tx_byte (hc_tx),
    .miso    (1'b0),
    .sclk    (hc595_sclk),
    .mosi    (hc595_dat),
    .done    (hc_done),
    .rx_byte (unused_hc_rx)
  );

  always_comb begin
    state_d = state;
    unique case (state)
      S_IDLE: if (run) state_d = S_CMD;
      S_CMD: begin
        if (!run) state_d = S_IDLE;
        else if (ee_done && cnt == CW'(ADDR_BYTES))
          state_d = S_LOAD;
      end
      S_LOAD: begin
        if (!run) state_d = S_IDLE;
        else if (ee_done && cnt == CW'(N - 1))
          state_d = LOAD_NEXT;
      end
`ifdef FRAME_CHECKSUM_EN
      S_CHECK: begin
        if (!run) state_d = S_IDLE;
        else if (ee_done)
          state_d = (ee_rx == csum) ? S_RUN : S_ERROR;
      end
      S_ERROR: if (!run) state_d = S_IDLE;
`endif
      S_RUN: if (!run) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_burst = (state == S_CMD) || (state == S_LOAD) ||
               (state == S_CHECK);
    ee_start = ee_go & in_burst & run;
    ee_abort = in_burst & ~run;
    buf_we   = (state == S_LOAD) & run & ee_done;
    ee_tx    = 8'h00;
    if (state == S_CMD) begin
      if (cnt == '0) ee_tx = EEPROM_READ_CMD;
      for (int i = 0; i < ADDR_BYTES; i++)
        if (cnt == CW'(ADDR_BYTES - i))
          ee_tx = START_ADDR[8*i +: 8];
    end
    col_go   = (state == S_RUN) & run & col_strobe & ~busy_q;
    hc_next  = (state == S_RUN) & run & hc_done & (bidx != 2'd0);
    hc_start = col_go | hc_next;
    hc_abort = ~run;
    hc_idx   = IW'(ptr) * IW'(BYTES_PER_COL) +
               IW'(busy_q ? bidx - 2'd1 : 2'(BYTES_PER_COL - 1));
    hc_tx    = frame_buf[hc_idx];
    if (dir_q)
      ptr_nxt = (ptr == PW'(COLUMNS - 1)) ? '0 : ptr + PW'(1);
    else
      ptr_nxt = (ptr == '0) ? PW'(COLUMNS - 1) : ptr - PW'(1);
  end

  always_ff @(posedge clk) begin
    if (buf_we) frame_buf[cnt[IW-1:0]] <= ee_rx;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      ee_go     <= 1'b0;
      ptr       <= '0;
      dir_q     <= 1'b0;
      busy_q    <= 1'b0;
      latch_q   <= 1'b0;
      overrun_q <= 1'b0;
      bidx      <= '0;
`ifdef FRAME_CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      state   <= state_d;
      ee_go   <= 1'b0;
      latch_q <= 1'b0;
      if (state == S_IDLE && run) begin
        cnt       <= '0;
        ee_go     <= 1'b1;
        overrun_q <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
        csum      <= '0;
`endif
      end
      if (in_burst && run && ee_done) begin
        ee_go <= (state_d == S_CMD) || (state_d == S_LOAD) ||
                 (state_d == S_CHECK);
        if (state == S_CMD && state_d == S_LOAD) cnt <= '0;
        else cnt <= cnt + CW'(1);
`ifdef FRAME_CHECKSUM_EN
        if (state == S_LOAD) csum <= csum ^ ee_rx;
`endif
      end
      if (state == S_RUN && run) begin
        if (col_strobe && busy_q) overrun_q <= 1'b1;
        if (col_go) begin
          busy_q <= 1'b1;
          dir_q  <= dir;
          bidx   <= 2'(BYTES_PER_COL - 1);
        end else if (latch_q) begin
          busy_q <= 1'b0;
        end else if (hc_done) begin
          if (bidx != 2'd0) begin
            bidx <= bidx - 2'd1;
          end else begin
            latch_q <= 1'b1;
            ptr     <= ptr_nxt;
          end
        end
      end else begin
        busy_q <= 1'b0;
      end
    end
  end

  assign eeprom_cs_n = ~in_burst;
  assign hc595_latch = latch_q;
  assign loaded      = (state == S_RUN);
  assign busy        = busy_q;
  assign overrun     = overrun_q;
`ifdef FRAME_CHECKSUM_EN
  assign error       = (state == S_ERROR);
`else
  assign error       = 1'b0;
`endif

endmodule

// File: tb/tb_pov_frame_streamer.sv
// tb_pov_frame_streamer: directed bench with EEPROM and HC595
// behavioural models; 4 columns x 2 bytes, 2 address bytes.
`timescale 1ns/1ps
module tb_pov_frame_streamer;

  localparam int COLUMNS    = 4;
  localparam int BPC        = 2;
  localparam int ADDR_BYTES = 2;
`ifdef FRAME_CHECKSUM_EN
  localparam int BITS_EXP = 96;
`else
  localparam int BITS_EXP = 88;
`endif

  logic clk = 1'b0;
  logic nreset = 1'b0;
  logic run = 1'b0;
  logic col_strobe = 1'b0;
  logic dir = 1'b0;
  logic eeprom_miso;
  logic eeprom_cs_n, eeprom_sclk, eeprom_mosi;
  logic hc595_sclk, hc595_dat, hc595_latch;
  logic loaded, busy, overrun, error;

  always #5 clk = ~clk;

  pov_frame_streamer #(
    .COLUMNS       (COLUMNS),
    .BYTES_PER_COL (BPC),
    .ADDR_BYTES    (ADDR_BYTES),
    .START_ADDR    (16'h0010),
    .SCLK_DIV      (1)
  ) dut (
    .clk         (clk),
    .nreset      (nreset),
    .run         (run),
    .col_strobe  (col_strobe),
    .dir         (dir),
    .eeprom_miso (eeprom_miso),
    .eeprom_cs_n (eeprom_cs_n),
    .eeprom_sclk (eeprom_sclk),
    .eeprom_mosi (eeprom_mosi),
    .hc595_sclk  (hc595_sclk),
    .hc595_dat   (hc595_dat),
    .hc595_latch (hc595_latch),
    .loaded      (loaded),
    .busy        (busy),
    .overrun     (overrun),
    .error       (error)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  // EEPROM model
  logic [7:0]  ee_mem [0:8];
  logic [7:0]  byte_v;
  logic [23:0] mosi_sr, hdr;
  int          bitcnt = 0;
  int          n_hdr = 0;

  always @(posedge eeprom_sclk or negedge eeprom_cs_n) begin
    if (!eeprom_sclk) begin
      bitcnt  = 0;
      mosi_sr = '0;
    end else if (!eeprom_cs_n) begin
      mosi_sr = {mosi_sr[22:0], eeprom_mosi};
      bitcnt++;
      if (bitcnt == 24) begin
        hdr = mosi_sr;
        n_hdr++;
      end
    end
  end

  always @(negedge eeprom_sclk) begin
    if (bitcnt >= 24 && bitcnt < 24 + 8 * 9) begin
      byte_v      = ee_mem[(bitcnt - 24) / 8];
      eeprom_miso = byte_v[7 - (bitcnt % 8)];
    end else begin
      eeprom_miso = 1'b0;
    end
  end

  // HC595 model
  logic [15:0] hc_sr = '0;
  logic [15:0] hc_out = '0;
  int          hc_edges = 0;
  int          n_latch = 0;

  always @(posedge hc595_sclk) begin
    hc_sr = {hc_sr[14:0], hc595_dat};
    hc_edges++;
  end

  always @(posedge hc595_latch) begin
    hc_out = hc_sr;
    n_latch++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic strobe(input logic d);
    dir        = d;
    col_strobe = 1'b1;
    @(negedge clk);
    col_strobe = 1'b0;
  endtask

  task automatic wait_latch(input string tag);
    int k = 0;
    while (!hc595_latch && k < 200) begin
      @(negedge clk);
      k++;
    end
    check({tag, " latch seen"}, 32'(hc595_latch), 1);
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (!(loaded || error) && k < 400) begin
      @(negedge clk);
      k++;
    end
    check({tag, " burst end"}, 32'(loaded | error), 1);
  endtask

  task automatic column(input string tag, input logic d,
                        input logic [15:0] exp);
    int e0;
    e0 = hc_edges;
    strobe(d);
    check({tag, " busy"}, 32'(busy), 1);
    wait_latch(tag);
    @(negedge clk);
    check({tag, " data"}, 32'(hc_out), 32'(exp));
    check({tag, " edges"}, hc_edges - e0, 16);
    check({tag, " latch 1clk"}, 32'(hc595_latch), 0);
    check({tag, " busy low"}, 32'(busy), 0);
  endtask

  int e0, e1, l0, h0, k;

  initial begin
    for (int i = 0; i < 8; i++) ee_mem[i] = 8'h11 + 8'(i);
    ee_mem[8] = 8'h08;
    tick(3);
    check("rst cs_n", 32'(eeprom_cs_n), 1);
    check("rst ee sclk", 32'(eeprom_sclk), 0);
    check("rst ee mosi", 32'(eeprom_mosi), 0);
    check("rst hc sclk", 32'(hc595_sclk), 0);
    check("rst hc dat", 32'(hc595_dat), 0);
    check("rst latch", 32'(hc595_latch), 0);
    check("rst loaded", 32'(loaded), 0);
    check("rst busy", 32'(busy), 0);
    check("rst overrun", 32'(overrun), 0);
    check("rst error", 32'(error), 0);
    nreset = 1'b1;
    tick(2);

    strobe(1'b1);
    tick(3);
    check("idle strobe overrun", 32'(overrun), 0);
    check("idle strobe shift", hc_edges, 0);
    check("idle cs_n", 32'(eeprom_cs_n), 1);

    run = 1'b1;
    wait_done("load");
    check("load hdr", 32'(hdr), 32'h030010);
    check("load bits", bitcnt, BITS_EXP);
    check("load cs_n", 32'(eeprom_cs_n), 1);
    check("load loaded", 32'(loaded), 1);
    check("load error", 32'(error), 0);

    column("col0 fwd", 1'b1, 16'h1211);
    column("col1 rev", 1'b0, 16'h1413);
    column("wrap rev", 1'b0, 16'h1211);
    column("col3 rev", 1'b0, 16'h1817);

    e0 = hc_edges;
    l0 = n_latch;
    strobe(1'b1);
    tick(4);
    strobe(1'b1);
    check("ovr flag", 32'(overrun), 1);
    wait_latch("ovr");
    tick(10);
    check("ovr data", 32'(hc_out), 32'h1615);
    check("ovr edges", hc_edges - e0, 16);
    check("ovr latches", n_latch - l0, 1);
    check("ovr sticky", 32'(overrun), 1);

    l0 = n_latch;
    strobe(1'b1);
    tick(5);
    run = 1'b0;
    @(negedge clk);
    e1 = hc_edges;
    check("rabort sclk", 32'(hc595_sclk), 0);
    check("rabort dat", 32'(hc595_dat), 0);
    check("rabort busy", 32'(busy), 0);
    check("rabort loaded", 32'(loaded), 0);
    tick(40);
    check("rabort edges", hc_edges - e1, 0);
    check("rabort latches", n_latch - l0, 0);
    check("idle overrun kept", 32'(overrun), 1);

    run = 1'b1;
    @(negedge clk);
    check("cmd clears overrun", 32'(overrun), 0);
    k = 0;
    while (bitcnt < 58 && k < 300) begin
      @(negedge clk);
      k++;
    end
    run = 1'b0;
    @(negedge clk);
    check("labort cs_n", 32'(eeprom_cs_n), 1);
    check("labort sclk", 32'(eeprom_sclk), 0);
    check("labort loaded", 32'(loaded), 0);
    check("labort in byte4", 32'(bitcnt >= 56 && bitcnt < 64), 1);

    tick(3);
    h0 = n_hdr;
    run = 1'b1;
    wait_done("reload");
    check("reload hdr", 32'(hdr), 32'h030010);
    check("reload hdr count", n_hdr - h0, 1);
    check("reload bits", bitcnt, BITS_EXP);
    column("reload col3", 1'b1, 16'h1817);
    column("reload wrap", 1'b1, 16'h1211);

`ifdef FRAME_CHECKSUM_EN
    run = 1'b0;
    tick(3);
    ee_mem[8] = 8'h00;
    run = 1'b1;
    wait_done("csum bad");
    check("csum bad error", 32'(error), 1);
    check("csum bad loaded", 32'(loaded), 0);
    check("csum bad cs_n", 32'(eeprom_cs_n), 1);
    run = 1'b0;
    @(negedge clk);
    check("csum error clear", 32'(error), 0);
    ee_mem[8] = 8'h08;
    tick(2);
    run = 1'b1;
    wait_done("csum good");
    check("csum good loaded", 32'(loaded), 1);
    check("csum good error", 32'(error), 0);
`else
    check("error tied", 32'(error), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
